// File: rtl/snow64_instr_decode_unit.sv
// Snow64 instruction decoder: zero-latency decode of one instruction word into a flat bundle,
// plus a clocked monitor that counts illegal encodings seen on valid fetches.
module snow64_instr_decode_unit #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic                   in_valid,
    output logic [2:0]             out_group,
    output logic [3:0]             out_ra_index,
    output logic [3:0]             out_rb_index,
    output logic [3:0]             out_rc_index,
    output logic [3:0]             out_oper,
    output logic [2:0]             out_op_type,
    output logic [ADDR_WIDTH-1:0]  out_signext_imm,
    output logic                   out_nop,
    output logic                   out_illegal,
    output logic                   out_illegal_seen,
    output logic [CNT_WIDTH-1:0]   out_illegal_count
);

    logic [2:0]  f_group;
    logic [3:0]  f_oper;
    logic [12:0] f_imm13;
    logic        legal;

    assign f_group = in_instr[31:29];
    assign f_oper  = in_instr[16:13];
    assign f_imm13 = in_instr[12:0];

    always_comb begin
        legal = 1'b0;
        unique case (f_group)
            3'd0:       legal = (f_oper <= 4'd13);
            3'd1:       legal = (f_oper <= 4'd2);
            3'd2, 3'd3: legal = (f_oper <= 4'd7);
            default:    legal = 1'b0;
        endcase
    end

    assign out_illegal = ~legal;
    assign out_nop     = (in_instr == '0) | ~legal;

    // A bubble is an all-zero bundle so downstream never acts on stale fields.
    always_comb begin
        out_group       = '0;
        out_ra_index    = '0;
        out_rb_index    = '0;
        out_rc_index    = '0;
        out_oper        = '0;
        out_op_type     = '0;
        out_signext_imm = '0;
        if (!out_nop) begin
            out_group    = f_group;
            out_ra_index = in_instr[28:25];
            out_rb_index = in_instr[24:21];
            out_rc_index = in_instr[20:17];
            out_oper     = f_oper;
            if (f_group == 3'd0) begin
                out_op_type = in_instr[12:10];
            end else begin
                out_signext_imm = {{(ADDR_WIDTH-13){f_imm13[12]}}, f_imm13};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_illegal_seen  <= 1'b0;
            out_illegal_count <= '0;
        end else if (in_valid && out_illegal) begin
            out_illegal_seen <= 1'b1;
            if (out_illegal_count != {CNT_WIDTH{1'b1}}) begin
                out_illegal_count <= out_illegal_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snow64_instr_decode_unit.sv
// Directed bench for snow64_instr_decode_unit with a rule-level reference model and per-cycle compare.
module tb_snow64_instr_decode_unit;

    logic        clk;
    logic        rst;
    logic [31:0] in_instr;
    logic        in_valid;
    logic [2:0]  out_group;
    logic [3:0]  out_ra_index;
    logic [3:0]  out_rb_index;
    logic [3:0]  out_rc_index;
    logic [3:0]  out_oper;
    logic [2:0]  out_op_type;
    logic [63:0] out_signext_imm;
    logic        out_nop;
    logic        out_illegal;
    logic        out_illegal_seen;
    logic [15:0] out_illegal_count;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  started  = 0;
    int  m_cnt;
    bit  m_seen;

    snow64_instr_decode_unit #(
        .INSTR_WIDTH(32),
        .ADDR_WIDTH (64),
        .CNT_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_instr         (in_instr),
        .in_valid         (in_valid),
        .out_group        (out_group),
        .out_ra_index     (out_ra_index),
        .out_rb_index     (out_rb_index),
        .out_rc_index     (out_rc_index),
        .out_oper         (out_oper),
        .out_op_type      (out_op_type),
        .out_signext_imm  (out_signext_imm),
        .out_nop          (out_nop),
        .out_illegal      (out_illegal),
        .out_illegal_seen (out_illegal_seen),
        .out_illegal_count(out_illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle layout: {group, ra, rb, rc, oper, op_type, imm64, nop, illegal}
    function automatic logic [87:0] model(input logic [31:0] w);
        int unsigned lim[4] = '{13, 2, 7, 7};
        int unsigned g      = w >> 29;
        int unsigned oper   = (w >> 13) & 15;
        longint      imm    = longint'(w & 32'h1FFF);
        bit          legal  = (g < 4) && (oper <= lim[g]);
        if (imm >= 4096) imm = imm - 8192;
        if (!legal || w == 0) return {86'd0, 1'b1, !legal};
        return {3'(g), 4'(w >> 25), 4'(w >> 21), 4'(w >> 17), 4'(oper),
                (g == 0) ? 3'(w >> 10) : 3'd0, (g == 0) ? 64'd0 : 64'(imm), 1'b0, 1'b0};
    endfunction

    function automatic logic [87:0] actual();
        return {out_group, out_ra_index, out_rb_index, out_rc_index, out_oper, out_op_type,
                out_signext_imm, out_nop, out_illegal};
    endfunction

    function automatic bit model_illegal(input logic [31:0] w);
        logic [87:0] b = model(w);
        return b[0];
    endfunction

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (instr %h)", name, act, exp, in_instr);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_seen <= 0;
        end else if (in_valid && model_illegal(in_instr)) begin
            m_seen <= 1;
            m_cnt  <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("decode_vs_model", actual(), model(in_instr));
            check("monitor_vs_model", {71'd0, out_illegal_seen, out_illegal_count},
                  {71'd0, m_seen, 16'(m_cnt)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] w, input logic v);
        in_instr = w;
        in_valid = v;
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_instr = '0;
        in_valid = 1'b0;
        tick();
        tick();
        started = 1;
        check("reset_count", 88'(out_illegal_count), 88'd0);
        check("reset_seen", 88'(out_illegal_seen), 88'd0);
        rst = 1'b0;

        // All-zero word is a bubble, not illegal, and never counts.
        apply(32'h0000_0000, 1'b1);
        check("zero_bundle", actual(), {86'd0, 1'b1, 1'b0});
        tick();
        check("zero_no_count", 88'(out_illegal_count), 88'd0);

        apply(32'h13A4_2C00, 1'b0);
        check("alu_bundle", actual(),
              {3'd0, 4'd9, 4'd13, 4'd2, 4'd1, 3'd3, 64'd0, 1'b0, 1'b0});
        tick();

        apply(32'h2000_1FFC, 1'b0);
        check("branch_imm", 88'(out_signext_imm), 88'(64'hFFFF_FFFF_FFFF_FFFC));
        check("branch_group_nop", {85'd0, out_group, out_nop}, {85'd0, 3'd1, 1'b0});
        check("branch_op_type", 88'(out_op_type), 88'd0);
        tick();

        apply(32'h2000_7FFC, 1'b0);
        check("branch_oper3_illegal", actual(), {86'd0, 1'b1, 1'b1});
        tick();

        apply(32'h4000_A010, 1'b0);
        check("load_imm", 88'(out_signext_imm), 88'h10);
        check("load_oper", {84'd0, out_oper}, {84'd0, 4'd5});
        tick();

        apply(32'h6001_0000, 1'b0);
        check("store_oper8_illegal", {86'd0, out_nop, out_illegal}, {86'd0, 1'b1, 1'b1});
        tick();

        apply(32'h0001_A000, 1'b0);
        check("alu_oper13_legal", {86'd0, out_nop, out_illegal}, 88'd0);
        tick();
        apply(32'h0001_C000, 1'b0);
        check("alu_oper14_illegal", {86'd0, out_nop, out_illegal}, {86'd0, 1'b1, 1'b1});
        tick();
        apply(32'hE000_0000, 1'b0);
        check("group7_illegal", 88'(out_illegal), 88'd1);
        tick();

        // Monitor: three valid illegal words, one invalid, then reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply(32'hC000_0000, 1'b1);
        repeat (3) tick();
        apply(32'hC000_0000, 1'b0);
        tick();
        check("count_three", 88'(out_illegal_count), 88'd3);
        check("seen_set", 88'(out_illegal_seen), 88'd1);
        rst = 1'b1;
        apply(32'hC000_0000, 1'b1);
        tick();
        check("rst_count", 88'(out_illegal_count), 88'd0);
        check("rst_seen", 88'(out_illegal_seen), 88'd0);
        check("rst_keeps_decode", 88'(out_illegal), 88'd1);
        rst = 1'b0;

        repeat (65534) tick();
        check("count_fffe", 88'(out_illegal_count), 88'hFFFE);
        repeat (3) tick();
        check("count_saturated", 88'(out_illegal_count), 88'hFFFF);
        apply(32'h0000_0000, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snow64_instr_decode_unit.md
Name: snow64_instr_decode_unit

Overview:
- Decodes one 32-bit Snow64 instruction word into a flat decoded-instruction bundle: group, register indices, oper, op_type, sign-extended immediate and nop flag.
- Sits between the instruction-cache output and the IF/ID pipe stage.
- The decode path is purely combinational (zero latency) because IF/ID consumes the bundle in the same cycle the cache presents the word.
- A small clocked monitor records illegal encodings for debug.

Parameters:
- INSTR_WIDTH, 32, instruction word width (fixed; other values unsupported).
- ADDR_WIDTH, 64, width of the signext_imm output (CPU address width).
- CNT_WIDTH, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_instr  in  32  instruction word.
- in_valid  in  1  in_instr is a real fetched word (cache hit); qualifies the monitor only.
- out_group  out  3  instruction group: 0 ALU/FPU, 1 control flow, 2 load, 3 store.
- out_ra_index  out  4  LAR index A.
- out_rb_index  out  4  LAR index B.
- out_rc_index  out  4  LAR index C.
- out_oper  out  4  operation within group.
- out_op_type  out  3  data type (group 0 only).
- out_signext_imm  out  ADDR_WIDTH  sign-extended immediate.
- out_nop  out  1  instruction is a no-op/bubble.
- out_illegal  out  1  combinational: current word is an illegal encoding.
- out_illegal_seen  out  1  sticky flag.
- out_illegal_count  out  CNT_WIDTH  saturating count of illegal words.

Behaviour:
- Field map:
  - group = instr[31:29]; ra = [28:25]; rb = [24:21]; rc = [20:17]; oper = [16:13].
  - op_type = [12:10]; imm13 = [12:0].
- Legality:
  - group 0: oper 0..13 legal, 14..15 illegal; op_type any value.
  - group 1: oper 0..2 legal.
  - groups 2 and 3: oper 0..7 legal.
  - groups 4..7: always illegal.
- out_illegal = 1 iff the encoding is not legal.
- out_nop = 1 iff in_instr == 0 or the word is illegal.
- When out_nop = 1: group, indices, oper, op_type and signext_imm are all driven 0. A bubble therefore equals an all-zero bundle apart from nop.
- When out_nop = 0:
  - Fields pass through as mapped.
  - op_type forced 0 unless group == 0.
  - signext_imm = imm13 sign-extended from bit 12 to ADDR_WIDTH for groups 1..3; 0 for group 0.
- Downstream contract: group 1 with nop = 0 means "changes PC".
- Decode outputs depend only on in_instr (no clk or rst). An X-free input gives X-free outputs.
- Monitor, evaluated on every posedge clk:
  - rst = 1: out_illegal_seen <= 0, out_illegal_count <= 0. rst has priority over in_valid.
  - else if in_valid and out_illegal: seen <= 1; count <= count + 1, saturating at all-ones (no wrap).
  - in_valid = 0: no update, regardless of in_instr.
  - An all-zero word is a NOP, not illegal, and does not count.
- Reset mid-run clears the monitor only; the combinational decode is unaffected.

Test Plan:
- in_instr = 0x00000000 -> nop=1, all other decode fields 0, illegal=0; with in_valid=1 count stays 0.
- Group 0 word 0x13A4_2C00 (group 0, ra 9, rb 13, rc 2, oper 1, op_type 3) -> nop=0, group=0, ra=9, rb=13, rc=2, oper=1, op_type=3, signext_imm=0.
- Group 1 word with oper 0 and imm13 = 0x1FFC (-4) -> group=1, nop=0, signext_imm=0xFFFF_FFFF_FFFF_FFFC, op_type=0. Same word with oper 3 -> nop=1, illegal=1, all fields 0.
- Load (group 2, oper 5, imm13 = 0x0010) -> signext_imm=0x10. Store (group 3, oper 8) -> illegal.
- Word with group 6 presented 3 cycles with in_valid=1, then 1 cycle with in_valid=0 -> count=3, seen=1. Assert rst for one cycle -> both 0 next cycle.
- Preload count to 0xFFFE via illegal stream, then 3 more illegal valid words -> count holds 0xFFFF.
